// File: rtl/tea_decrypt_core.sv
// -----------------------------------------------------------------------------
// tea_decrypt_core
//
// Iterative TEA decryption engine: one inverse round per clock. This block
// undoes the companion encryption core, so ROUNDS and DELTA must match the
// values used there.
//
// Handshake: start is sampled only while idle. On acceptance the ciphertext
// and key are captured, so the inputs may change on the next cycle. After
// ROUNDS inverse rounds the plaintext is registered onto left_out/right_out
// and done pulses for one cycle. The outputs hold that value until the next
// completion or until reset. A start seen while busy is dropped.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       begin a decryption (honoured only when idle)
//   left_in     ciphertext word v0
//   right_in    ciphertext word v1
//   key1..key4  key words k0..k3 (same ordering as the encryption core)
//   left_out    plaintext word v0, held between completions
//   right_out   plaintext word v1, held between completions
//   done        one-cycle pulse; the outputs are valid in that cycle
//   busy        high whenever the FSM is not idle
//   dbg_state_o raw FSM state register, for debug and checkers
// -----------------------------------------------------------------------------
module tea_decrypt_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    input  logic [31:0] key1,
    input  logic [31:0] key2,
    input  logic [31:0] key3,
    input  logic [31:0] key4,
    output logic [31:0] left_out,
    output logic [31:0] right_out,
    output logic        done,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DECRYPT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    // The decryptor starts from the sum the encryptor finishes with.
    // Counting down by DELTA brings it back to zero after the last round.
    localparam logic [31:0] SUM_INIT  = 32'(DELTA * ROUNDS);
    localparam logic [5:0]  ROUNDS_M1 = 6'(ROUNDS - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] v_left_q, v_left_d;
    logic [31:0] v_right_q, v_right_d;
    logic [31:0] sum_q, sum_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [31:0] left_out_q, left_out_d;
    logic [31:0] right_out_q, right_out_d;
    logic        done_q, done_d;

    // One inverse round. The encryptor updates v0 before v1, so the
    // decryptor must restore v1 first. The new v1 then feeds the v0 step.
    logic [31:0] right_next;
    logic [31:0] left_next;

    assign right_next = v_right_q - (((v_left_q << 4) + k2_q) ^ (v_left_q + sum_q) ^
                                     ((v_left_q >> 5) + k3_q));
    assign left_next  = v_left_q - (((right_next << 4) + k0_q) ^ (right_next + sum_q) ^
                                    ((right_next >> 5) + k1_q));

    always_comb begin
        state_d     = state_q;
        v_left_d    = v_left_q;
        v_right_d   = v_right_q;
        sum_d       = sum_q;
        round_d     = round_q;
        k0_d        = k0_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        k3_d        = k3_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    v_left_d  = left_in;
                    v_right_d = right_in;
                    k0_d      = key1;
                    k1_d      = key2;
                    k2_d      = key3;
                    k3_d      = key4;
                    sum_d     = SUM_INIT;
                    round_d   = 6'd0;
                    state_d   = DECRYPT;
                end
            end
            DECRYPT: begin
                v_right_d = right_next;
                v_left_d  = left_next;
                sum_d     = sum_q - DELTA;
                round_d   = round_q + 6'd1;
                // The last round is still applied on this edge, which gives
                // exactly ROUNDS updates in total.
                if (round_q == ROUNDS_M1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                left_out_d  = v_left_q;
                right_out_d = v_right_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            v_left_q    <= 32'd0;
            v_right_q   <= 32'd0;
            sum_q       <= 32'd0;
            round_q     <= 6'd0;
            k0_q        <= 32'd0;
            k1_q        <= 32'd0;
            k2_q        <= 32'd0;
            k3_q        <= 32'd0;
            left_out_q  <= 32'd0;
            right_out_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_left_q    <= v_left_d;
            v_right_q   <= v_right_d;
            sum_q       <= sum_d;
            round_q     <= round_d;
            k0_q        <= k0_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            k3_q        <= k3_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            done_q      <= done_d;
        end
    end

    assign left_out    = left_out_q;
    assign right_out   = right_out_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Bench for tea_decrypt_core.
//
// Handshake under test: start is accepted only on an edge where the core is
// idle. done pulses for one cycle with left_out/right_out valid, and those
// outputs hold until the next done.
//
// Reference: a plain TEA encryption loop. Each block is formed by encrypting
// a known plaintext, and the expected decryptor output is that plaintext.
module tb_tea_decrypt_core;

  localparam int unsigned ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] left_in, right_in;
  logic [31:0] key1, key2, key3, key4;
  logic [31:0] left_out, right_out;
  logic        done, busy;
  logic [1:0]  dbg_state;

  tea_decrypt_core #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .left_in    (left_in),
    .right_in   (right_in),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .key4       (key4),
    .left_out   (left_out),
    .right_out  (right_out),
    .done       (done),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          checks;
  int          errors;
  logic [31:0] hold_l, hold_r;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                          input logic [31:0] k0, input logic [31:0] k1,
                                          input logic [31:0] k2, input logic [31:0] k3);
    logic [31:0] v0, v1, s;
    v0 = p0;
    v1 = p1;
    s  = 32'd0;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
    end
    return {v0, v1};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending block");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check32("left_out", left_out, e[63:32]);
        check32("right_out", right_out, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Caller is at a negedge when b2b is set; otherwise wait for one.
  // Returns at the negedge where done is observed.
  task automatic run_block(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] k0, input logic [31:0] k1,
                           input logic [31:0] k2, input logic [31:0] k3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input bit b2b, input bit busy_start, input bit chg_inputs);
    int c;
    int busy_cnt;
    bit seen;
    if (!b2b) @(negedge clk);
    start    = 1'b1;
    left_in  = c0;
    right_in = c1;
    key1     = k0;
    key2     = k1;
    key3     = k2;
    key4     = k3;
    exp_q.push_back({e0, e1});
    @(posedge clk);
    #1;
    start = 1'b0;
    if (chg_inputs) begin
      left_in  = $urandom;
      right_in = $urandom;
      key1     = $urandom;
      key2     = $urandom;
      key3     = $urandom;
      key4     = $urandom;
    end
    busy_cnt = 0;
    seen     = 1'b0;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy_start && c == 10) begin
        start    = 1'b1;
        left_in  = $urandom;
        right_in = $urandom;
        key1     = $urandom;
      end else if (busy_start && c == 11) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (left_out !== hold_l || right_out !== hold_r) begin
        check32("hold_left", left_out, hold_l);
        check32("hold_right", right_out, hold_r);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done after %0d edges", ROUNDS + 1);
    end else begin
      check32("latency", 32'(c), 32'(ROUNDS + 1));
      check32("busy_cycles", 32'(busy_cnt), 32'(ROUNDS + 1));
      check32("busy_at_done", {31'd0, busy}, 32'd0);
    end
    hold_l = e0;
    hold_r = e1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] ct;
    logic [31:0] p0, p1, k0, k1, k2, k3;
    checks   = 0;
    errors   = 0;
    hold_l   = 32'd0;
    hold_r   = 32'd0;
    reset_n  = 1'b0;
    start    = 1'b0;
    left_in  = 32'd0;
    right_in = 32'd0;
    key1     = 32'd0;
    key2     = 32'd0;
    key3     = 32'd0;
    key4     = 32'd0;
    repeat (3) @(negedge clk);
    check32("reset_left", left_out, 32'd0);
    check32("reset_right", right_out, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Known vector: all-zero key, zero plaintext.
    run_block(32'h41EA3A0A, 32'h94BAA940, 32'd0, 32'd0, 32'd0, 32'd0,
              32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Round trip with the fixed key and plaintext.
    ct = tea_enc(32'h01234567, 32'h89ABCDEF,
                 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    run_block(ct[63:32], ct[31:0], 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
              32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0);

    // Back-to-back: issued in the done cycle of the previous block.
    ct = tea_enc(32'hDEADBEEF, 32'hCAFEF00D, 32'h1, 32'h2, 32'h3, 32'h4);
    run_block(ct[63:32], ct[31:0], 32'h1, 32'h2, 32'h3, 32'h4,
              32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);

    // Start while busy must be ignored.
    ct = tea_enc(32'h11111111, 32'h22222222, 32'hA, 32'hB, 32'hC, 32'hD);
    run_block(ct[63:32], ct[31:0], 32'hA, 32'hB, 32'hC, 32'hD,
              32'h11111111, 32'h22222222, 1'b0, 1'b1, 1'b0);

    // Inputs and key changed right after acceptance.
    ct = tea_enc(32'h33333333, 32'h44444444, 32'h5, 32'h6, 32'h7, 32'h8);
    run_block(ct[63:32], ct[31:0], 32'h5, 32'h6, 32'h7, 32'h8,
              32'h33333333, 32'h44444444, 1'b0, 1'b0, 1'b1);

    // Randomized blocks with mixed spacing and input disturbance.
    for (int i = 0; i < 6; i++) begin
      p0 = $urandom; p1 = $urandom;
      k0 = $urandom; k1 = $urandom; k2 = $urandom; k3 = $urandom;
      ct = tea_enc(p0, p1, k0, k1, k2, k3);
      run_block(ct[63:32], ct[31:0], k0, k1, k2, k3, p0, p1,
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));
    end

    // Reset in mid-operation: no done, outputs cleared.
    @(negedge clk);
    start    = 1'b1;
    left_in  = $urandom;
    right_in = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check32("midrst_left", left_out, 32'd0);
    check32("midrst_right", right_out, 32'd0);
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_done", {31'd0, done}, 32'd0);
    hold_l = 32'd0;
    hold_r = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check32("postrst_busy", {31'd0, busy}, 32'd0);

    // Fresh decryption after the reset.
    ct = tea_enc(32'h55AA55AA, 32'h0F0F0F0F, 32'h99, 32'h88, 32'h77, 32'h66);
    run_block(ct[63:32], ct[31:0], 32'h99, 32'h88, 32'h77, 32'h66,
              32'h55AA55AA, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard and catch any trailing extra done.
    repeat (60) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending blocks expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
